// File: rtl/song_sequencer_ctrl.sv
// ---------------------------------------------------------------------------
// song_sequencer_ctrl
//
// Purpose: tracker-style song sequencer. Tempo strobes advance a tick
// counter; every TICKS_PER_ROW strobes a row is fetched from a shared ROM
// (song entry -> per-channel pattern entry -> bar note) and committed to
// the per-channel note/gate outputs.
//
// Ports:
//   main_clk       clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   tick_stb       one-cycle tempo strobe
//   play           1 = run, 0 = pause (gates forced low)
//   song_len[7:0]  number of song entries (0 behaves as 1)
//   rom_req/rom_sel[1:0]/rom_addr[15:0]  ROM read request (sel 0/1/2 = song/pattern/bar)
//   rom_ack/rom_data[7:0]                ROM read completion and data
//   note_data[31:0] per-channel note byte, channel n in [8n+7:8n]
//   gate[3:0]       per-channel gate
//   song_position, bar_position  current song index / row
//   busy            row fetch in progress
//   overrun         sticky: a row boundary arrived while busy
//   done            song finished
//
// Build option: define SONG_SEQ_LOOP_EN to loop the song forever instead of
// stopping with done=1 after the last row.
// ---------------------------------------------------------------------------
module song_sequencer_ctrl #(
    parameter int NUM_CHANNELS  = 4,
    parameter int ROWS_PER_BAR  = 16,
    parameter int TICKS_PER_ROW = 8,
    parameter int GATE_TICKS    = 1
) (
    input  logic        main_clk,
    input  logic        rst,
    input  logic        tick_stb,
    input  logic        play,
    input  logic [7:0]  song_len,
    output logic        rom_req,
    output logic [1:0]  rom_sel,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic [31:0] note_data,
    output logic [3:0]  gate,
    output logic [7:0]  song_position,
    output logic [7:0]  bar_position,
    output logic        busy,
    output logic        overrun,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SONG,
        ST_PAT,
        ST_BAR,
        ST_COMMIT
    } state_e;

    localparam logic [1:0]  SEL_SONG = 2'd0;
    localparam logic [1:0]  SEL_PAT  = 2'd1;
    localparam logic [1:0]  SEL_BAR  = 2'd2;
    localparam logic [1:0]  LAST_CH  = 2'(NUM_CHANNELS - 1);
    localparam logic [7:0]  LAST_ROW = 8'(ROWS_PER_BAR - 1);
    localparam logic [7:0]  LAST_TCK = 8'(TICKS_PER_ROW - 1);
    localparam logic [15:0] ROWS16   = 16'(ROWS_PER_BAR);
    // The row-start strobe already moves tick_cnt to 1, so the gate is held
    // for GATE_TICKS further strobes and drops when tick_cnt reaches this.
    localparam logic [7:0]  GATE_CLR = 8'((GATE_TICKS + 1) % TICKS_PER_ROW);

    state_e      state_q, state_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic        rom_req_q, rom_req_d;
    logic [1:0]  rom_sel_q, rom_sel_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [7:0]  pat_q, pat_d;
    logic [7:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  ch_q, ch_d;
    logic [31:0] note_buf_q, note_buf_d;
    logic [31:0] note_q, note_d;
    logic [3:0]  gate_q, gate_d;
    logic [7:0]  song_pos_q, song_pos_d;
    logic [7:0]  bar_pos_q, bar_pos_d;
    logic        overrun_q, overrun_d;
    logic        done_q, done_d;

    logic        tick_run;
    logic        row_start;
    logic        req_done;
    logic [7:0]  song_last;

    always_comb begin
        // NOTE: every variable gets its default first, so no path through the
        // case below can leave a value unassigned and infer a latch.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        rom_req_d  = rom_req_q;
        rom_sel_d  = rom_sel_q;
        rom_addr_d = rom_addr_q;
        pat_d      = pat_q;
        bar_idx_d  = bar_idx_q;
        ch_d       = ch_q;
        note_buf_d = note_buf_q;
        note_d     = note_q;
        gate_d     = gate_q;
        song_pos_d = song_pos_q;
        bar_pos_d  = bar_pos_q;
        overrun_d  = overrun_q;
        done_d     = done_q;

        tick_run  = tick_stb && play && !done_q;
        row_start = tick_run && (tick_cnt_q == 8'd0);
        // An ack only counts while our request is actually up.
        req_done  = rom_req_q && rom_ack;
        song_last = (song_len == 8'd0) ? 8'd0 : song_len - 8'd1;

        if (tick_run) begin
            tick_cnt_d = (tick_cnt_q == LAST_TCK) ? 8'd0 : tick_cnt_q + 8'd1;
        end
        if (row_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (tick_run && (tick_cnt_d == GATE_CLR)) begin
            gate_d = '0;
        end
        if (!play || done_q) begin
            gate_d = '0;
        end

        // Each fetch state first raises its request (req low on entry), then
        // waits for the ack, drops the request and moves on.
        case (state_q)
            ST_IDLE: begin
                if (row_start) begin
                    state_d = ST_SONG;
                end
            end
            ST_SONG: begin
                if (!rom_req_q) begin
                    rom_req_d  = 1'b1;
                    rom_sel_d  = SEL_SONG;
                    rom_addr_d = {8'h00, song_pos_q};
                end else if (req_done) begin
                    rom_req_d = 1'b0;
                    pat_d     = rom_data;
                    ch_d      = 2'd0;
                    state_d   = ST_PAT;
                end
            end
            ST_PAT: begin
                if (!rom_req_q) begin
                    rom_req_d  = 1'b1;
                    rom_sel_d  = SEL_PAT;
                    rom_addr_d = {6'd0, pat_q, ch_q};  // pat*4 + ch
                end else if (req_done) begin
                    rom_req_d = 1'b0;
                    bar_idx_d = rom_data;
                    state_d   = ST_BAR;
                end
            end
            ST_BAR: begin
                if (!rom_req_q) begin
                    rom_req_d  = 1'b1;
                    rom_sel_d  = SEL_BAR;
                    rom_addr_d = {8'h00, bar_idx_q} * ROWS16 + {8'h00, bar_pos_q};
                end else if (req_done) begin
                    rom_req_d = 1'b0;
                    note_buf_d[{ch_q, 3'b000} +: 8] = rom_data;
                    if (ch_q == LAST_CH) begin
                        state_d = ST_COMMIT;
                    end else begin
                        ch_d    = ch_q + 2'd1;
                        state_d = ST_PAT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                // Empty note (upper nibble 0) leaves the channel untouched.
                for (int n = 0; n < NUM_CHANNELS; n++) begin
                    if (note_buf_q[8*n+4 +: 4] != 4'd0) begin
                        note_d[8*n +: 8] = note_buf_q[8*n +: 8];
                        gate_d[n]        = 1'b1;
                    end
                end
                if (bar_pos_q == LAST_ROW) begin
                    if (song_pos_q >= song_last) begin
`ifdef SONG_SEQ_LOOP_EN
                        bar_pos_d  = 8'd0;
                        song_pos_d = 8'd0;
`else
                        // Positions hold on the last row; done stops the clock.
                        done_d = 1'b1;
`endif
                    end else begin
                        bar_pos_d  = 8'd0;
                        song_pos_d = song_pos_q + 8'd1;
                    end
                end else begin
                    bar_pos_d = bar_pos_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge main_clk) begin
        // NOTE: non-blocking assignments only, so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 8'd0;
            rom_req_q  <= 1'b0;
            rom_sel_q  <= 2'd0;
            rom_addr_q <= 16'd0;
            pat_q      <= 8'd0;
            bar_idx_q  <= 8'd0;
            ch_q       <= 2'd0;
            note_buf_q <= 32'd0;
            note_q     <= 32'd0;
            gate_q     <= 4'd0;
            song_pos_q <= 8'd0;
            bar_pos_q  <= 8'd0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            rom_req_q  <= rom_req_d;
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
            pat_q      <= pat_d;
            bar_idx_q  <= bar_idx_d;
            ch_q       <= ch_d;
            note_buf_q <= note_buf_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            song_pos_q <= song_pos_d;
            bar_pos_q  <= bar_pos_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
        end
    end

    assign rom_req       = rom_req_q;
    assign rom_sel       = rom_sel_q;
    assign rom_addr      = rom_addr_q;
    assign note_data     = note_q;
    assign gate          = gate_q;
    assign song_position = song_pos_q;
    assign bar_position  = bar_pos_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;
    assign done          = done_q;

endmodule
